mod_req_arbiter: RTL and testbench
==================================

MOD_REQ_ARBITER -- requirements
Module: mod_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one req/ack resource (range 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the BUSY-state watchdog limit when the watchdog is compiled in (range 1..65535).
REQ-003 clk  input  1  SHALL be the single clock; all logic on posedge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req_i  input  NUM_REQ  SHALL carry per-requester level requests, each held until that requester's ack_o bit is seen.
REQ-006 ack_o  output  NUM_REQ  SHALL carry per-requester one-cycle completion pulses.
REQ-007 res_req_o  output  1  SHALL be the request to the shared resource.
REQ-008 res_ack_i  input  1  SHALL be the acknowledge from the shared resource.
REQ-009 grant_o  output  clog2(NUM_REQ)  SHALL give the index of the current or last granted requester.
REQ-010 busy_o  output  1  SHALL be high in every state except IDLE.
REQ-011 err_o  output  1  SHALL pulse for one cycle when a watchdog timeout completes a transaction.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 IDLE: if any req_i bit is high, the block SHALL register a round-robin winner (search starts at last grant + 1, wrapping at NUM_REQ-1 -> 0), update grant_o and enter BUSY next cycle; otherwise it SHALL stay in IDLE.
REQ-014 BUSY: res_req_o SHALL be 1 (registered); when res_ack_i = 1, the FSM SHALL enter DONE.
REQ-015 DONE (one cycle): res_req_o SHALL be 0, ack_o[grant] SHALL be 1 and all other ack_o bits 0; the FSM SHALL then return to IDLE unconditionally.
REQ-016 res_ack_i SHALL be ignored outside BUSY, to tolerate resources whose ack lags req by one cycle.
REQ-017 Latency SHALL be: req_i sampled in IDLE at cycle t -> res_req_o high at t+1 -> res_ack_i at t+k -> ack_o pulse at t+k+1 -> IDLE at t+k+2.
REQ-018 A requester dropping req_i while in BUSY SHALL NOT abort the transaction; it completes and ack_o still pulses.
REQ-019 Simultaneous requests SHALL be served one per transaction in rotating order, with no requester starved while it holds req_i.
REQ-020 A requester still holding req_i in the IDLE cycle after its own DONE SHALL be eligible only after the other active requesters in rotation order.

Reset
REQ-021 While rst = 1: state SHALL be IDLE; res_req_o, ack_o, err_o and busy_o SHALL be 0; grant_o SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-022 Reset asserted in BUSY or DONE SHALL abort the transaction with no ack_o pulse; res_req_o SHALL be 0 from the next cycle.

Configuration
REQ-023 With ARB_TIMEOUT_EN defined, a BUSY cycle counter (width clog2(TIMEOUT_CYCLES+1)) SHALL clear on entry to BUSY; when it reaches TIMEOUT_CYCLES without res_ack_i, the FSM SHALL enter DONE with both ack_o[grant] and err_o pulsing.
REQ-024 Without ARB_TIMEOUT_EN, no counter SHALL be built, err_o SHALL be tied 0, and BUSY SHALL wait indefinitely.
REQ-025 If res_ack_i and the timeout occur in the same cycle, the ack SHALL win and err_o SHALL stay 0.

Structure
REQ-026 Package mod_req_arbiter_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the default constants for NUM_REQ and TIMEOUT_CYCLES.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector and last grant; outputs: winner index and valid).

Verification
REQ-028 Single request: req_i=4'b0100, resource acks 3 cycles after res_req_o -> grant_o=2, exactly one ack_o=4'b0100 pulse, busy_o high for 5 cycles.
REQ-029 All four request continuously after reset -> grant order 0,1,2,3,0; each ack_o bit pulses once per rotation.
REQ-030 Lagging resource (ack = req delayed one cycle) with req_i=4'b0011 -> exactly two transactions, no spurious grant from the stale res_ack_i.
REQ-031 rst pulsed in the second BUSY cycle -> res_req_o=0 next cycle, no ack_o pulse, grant_o=3.
REQ-032 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, resource never acks -> ack_o[grant] and err_o pulse together 9 cycles after BUSY entry; without the macro busy_o stays high.
REQ-033 ARB_TIMEOUT_EN with res_ack_i arriving in the timeout cycle -> ack_o pulses and err_o=0.

Source files
------------

// File: rtl/mod_req_arbiter_pkg.sv
// Shared state encoding and default sizing for the request arbiter.
package mod_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DEF        = 4;
  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/mod_req_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester after last_i,
// wrapping from NUM_REQ-1 back to 0, so last_i itself is considered last.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       valid_o
);

  localparam int W = $clog2(NUM_REQ);

  logic [W-1:0] cand_s;
  logic [W-1:0] win_s;
  logic         found_s;
  logic         take_s;

  always_comb begin
    cand_s  = last_i;
    win_s   = last_i;
    found_s = 1'b0;
    take_s  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s  = W'((int'(last_i) + i) % NUM_REQ);
      take_s  = req_i[cand_s] & ~found_s;
      win_s   = take_s ? cand_s : win_s;
      found_s = found_s | req_i[cand_s];
    end
  end

  assign winner_o = win_s;
  assign valid_o  = found_s;

endmodule

// File: rtl/mod_req_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one req/ack resource.
// Optional BUSY watchdog is compiled in with `define ARB_TIMEOUT_EN.
module mod_req_arbiter
  import mod_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic                       res_req_o,
  input  logic                       res_ack_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [W-1:0]       grant_q, grant_d;
  logic [W-1:0]       win_s;
  logic               win_vld_s;
  logic               timeout_s;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               res_req_q, res_req_d;
  logic               busy_q, busy_d;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req_i),
    .last_i   (grant_q),
    .winner_o (win_s),
    .valid_o  (win_vld_s)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign timeout_s = (cnt_q == CW'(TIMEOUT_CYCLES));

  // Counter restarts from zero on every entry into BUSY.
  always_comb begin
    if ((state_q == BUSY) && (state_d == BUSY)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
    err_d = (state_q == BUSY) & ~res_ack_i & timeout_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= W'(NUM_REQ - 1);
      ack_q     <= '0;
      res_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      res_req_q <= res_req_d;
      busy_q    <= busy_d;
    end
  end

  // res_ack_i only matters in BUSY; a lagging ack in DONE/IDLE is dropped.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (win_vld_s) begin
          state_d = BUSY;
          grant_d = win_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (res_ack_i || timeout_s) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_req_d = (state_d == BUSY);
    busy_d    = (state_d != IDLE);
    if (state_d == DONE) begin
      ack_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_d;
    end else begin
      ack_d = '0;
    end
  end

  assign ack_o     = ack_q;
  assign res_req_o = res_req_q;
  assign grant_o   = grant_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_mod_req_arbiter.sv
// Self-checking bench for mod_req_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with hand-derived expectations.
module tb_mod_req_arbiter;

  localparam int N = 4;
  localparam int T = 8;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic [N-1:0] req_i     = '0;
  logic [N-1:0] ack_o;
  logic         res_req_o;
  logic         res_ack_i = 1'b0;
  logic [1:0]   grant_o;
  logic         busy_o;
  logic         err_o;

  always #5 clk = ~clk;

  mod_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .ack_o     (ack_o),
    .res_req_o (res_req_o),
    .res_ack_i (res_ack_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: phase 0 = waiting, 1 = resource held, 2 = completion cycle
  int  m_phase = 0;
  int  m_grant = N - 1;
  int  m_wait  = 0;
  bit  m_err   = 1'b0;
  int  m_log[$];
  bit  started = 1'b0;

  int           st_busy = 0;
  int           st_ack  = 0;
  int           st_err  = 0;
  logic [N-1:0] st_log[$];

  int          req_mode = 0;
  int          res_mode = 3;
  int          ack_dly  = 0;
  int unsigned ack_pct  = 30;
  int          rq_cnt   = 0;
  logic        prev_req = 1'b0;
  int          wait_n   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++) begin
      if (r[(last + i) % N]) return (last + i) % N;
    end
    return last;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_grant = N - 1;
      m_wait  = 0;
      m_err   = 1'b0;
    end else if (m_phase == 0) begin
      if (req_i != '0) begin
        m_grant = pick(req_i, m_grant);
        m_log.push_back(m_grant);
        m_phase = 1;
        m_wait  = 0;
      end
    end else if (m_phase == 1) begin
      if (res_ack_i) begin
        m_phase = 2;
        m_err   = 1'b0;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_wait == T) begin
        m_phase = 2;
        m_err   = 1'b1;
      end
`endif
      else begin
        m_wait++;
      end
    end else begin
      m_phase = 0;
    end
    started = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("res_req", res_req_o, m_phase == 1);
      chk("busy", busy_o, m_phase != 0);
      chk("ack", ack_o, (m_phase == 2) ? (32'd1 << m_grant) : 32'd0);
      chk("err", err_o, (m_phase == 2) && m_err);
      chk("grant", grant_o, m_grant);
      if (busy_o) st_busy++;
      if (ack_o != '0) begin
        st_ack++;
        st_log.push_back(ack_o);
      end
      if (err_o) st_err++;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
    case (req_mode)
      0: req_i = req_i & ~ack_o;
      1: req_i = req_i;
      default: begin
        for (int i = 0; i < N; i++) begin
          if (req_i[i] && ack_o[i]) req_i[i] = 1'b0;
          else if (!req_i[i] && $urandom_range(0, 99) < 20) req_i[i] = 1'b1;
          else if (req_i[i] && busy_o && $urandom_range(0, 99) < 3) req_i[i] = 1'b0;
        end
      end
    endcase
    case (res_mode)
      0: res_ack_i = ($urandom_range(0, 99) < ack_pct);
      1: begin
        rq_cnt    = res_req_o ? rq_cnt + 1 : 0;
        res_ack_i = (rq_cnt == ack_dly + 1);
      end
      2: begin
        res_ack_i = prev_req;
        prev_req  = res_req_o;
      end
      default: res_ack_i = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_mode  = 0;
    res_mode  = 3;
    req_i     = '0;
    res_ack_i = 1'b0;
    rq_cnt    = 0;
    prev_req  = 1'b0;
    cyc();
    cyc();
    chk("rst_grant", grant_o, N - 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_res_req", res_req_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_err", err_o, 0);
    rst     = 1'b0;
    st_busy = 0;
    st_ack  = 0;
    st_err  = 0;
    st_log.delete();
    m_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] exp_ack[5];
    int           exp_gnt[5];
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_gnt = '{0, 1, 2, 3, 0};

    // single request, resource acks 3 cycles after res_req_o
    do_reset();
    res_mode = 1; ack_dly = 3; req_i = 4'b0100;
    for (int i = 0; i < 14; i++) cyc();
    chk("s1_grant", grant_o, 2);
    chk("s1_busy_cycles", st_busy, 5);
    chk("s1_ack_count", st_ack, 1);
    chk("s1_ack_val", (st_log.size() > 0) ? st_log[0] : 4'b0000, 4'b0100);

    // all four requesting continuously
    do_reset();
    req_mode = 1; res_mode = 1; ack_dly = 0; req_i = '1;
    for (int i = 0; i < 40 && st_log.size() < 5; i++) cyc();
    chk("s2_ack_count", st_log.size() >= 5, 1);
    for (int k = 0; k < 5; k++) begin
      chk("s2_ack_order", (st_log.size() > k) ? st_log[k] : 4'b0000, exp_ack[k]);
      chk("s2_model_grant", (m_log.size() > k) ? m_log[k] : -1, exp_gnt[k]);
    end

    // lagging resource
    do_reset();
    res_mode = 2; req_i = 4'b0011;
    for (int i = 0; i < 30; i++) cyc();
    chk("s3_txns", st_ack, 2);
    chk("s3_busy_cycles", st_busy, 6);
    chk("s3_first", (st_log.size() > 0) ? st_log[0] : 4'b0000, 4'b0001);
    chk("s3_second", (st_log.size() > 1) ? st_log[1] : 4'b0000, 4'b0010);
    chk("s3_grant", grant_o, 1);

    // reset in second BUSY cycle
    do_reset();
    res_mode = 3; req_i = 4'b0001;
    for (int i = 0; i < 10 && !res_req_o; i++) cyc();
    chk("s4_busy_seen", res_req_o, 1);
    cyc();
    rst = 1'b1; req_i = '0;
    cyc();
    chk("s4_res_req", res_req_o, 0);
    chk("s4_no_ack", st_ack, 0);
    chk("s4_grant", grant_o, 3);
    rst = 1'b0;

    // resource never acks
    do_reset();
    res_mode = 3; req_i = 4'b1000;
    for (int i = 0; i < 10 && !res_req_o; i++) cyc();
    wait_n = 0;
    for (int i = 0; i < 30 && ack_o == '0; i++) begin
      cyc();
      wait_n++;
    end
`ifdef ARB_TIMEOUT_EN
    chk("s5_timeout_delay", wait_n, 9);
    chk("s5_err", err_o, 1);
    chk("s5_ack", ack_o, 4'b1000);
`else
    chk("s5_no_ack", st_ack, 0);
    chk("s5_still_busy", busy_o, 1);
    chk("s5_err", err_o, 0);
`endif

    // ack arrives exactly in the timeout cycle
    do_reset();
    res_mode = 1; ack_dly = T; req_i = 4'b0010;
    for (int i = 0; i < 20; i++) cyc();
    chk("s6_ack_count", st_ack, 1);
    chk("s6_err_count", st_err, 0);
    chk("s6_ack_val", (st_log.size() > 0) ? st_log[0] : 4'b0000, 4'b0010);

    // randomized traffic with occasional resets
    do_reset();
    req_mode = 2; res_mode = 0; ack_pct = 35;
    for (int i = 0; i < 1200; i++) begin
      cyc();
      rst = ($urandom_range(0, 199) == 0);
    end
    ack_pct = 6;
    for (int i = 0; i < 1200; i++) begin
      cyc();
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0; res_mode = 2;
    for (int i = 0; i < 300; i++) cyc();
    chk("s7_activity", st_ack > 50, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
